// File: rtl/image_encrypter_if.sv
// Image encrypter bus: start request, source-memory read port and
// destination-memory write port, plus busy/done status.
interface image_encrypter_if;
  logic        start;
  logic [7:0]  plain_data;
  logic [14:0] read_addr;
  logic [7:0]  encrypted_data;
  logic [14:0] write_addr;
  logic        write_en;
  logic        busy;
  logic        done;

  // The encrypter drives addresses, ciphertext and status.
  modport master (
    input  start,
    input  plain_data,
    output read_addr,
    output encrypted_data,
    output write_addr,
    output write_en,
    output busy,
    output done
  );

  // The environment (memories, controller) drives start and plaintext.
  modport slave (
    output start,
    output plain_data,
    input  read_addr,
    input  encrypted_data,
    input  write_addr,
    input  write_en,
    input  busy,
    input  done
  );
endinterface

// File: rtl/image_encrypter.sv
// Image encrypter: streams NUM_BYTES bytes from a source memory with one
// cycle of read latency, XORs each with a key and writes the result to a
// destination memory at the same address.
// Optional feature: define IMAGE_ENCRYPTER_ROLLING_KEY_EN to rotate the key
// left by one bit after every byte written.
module image_encrypter #(
  parameter logic [7:0] KEY       = 8'hB3,
  parameter int         NUM_BYTES = 19200
) (
  input  logic              clk,
  input  logic              rst_n,
  image_encrypter_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic [14:0] LAST_ADDR = 15'(NUM_BYTES - 1);

  logic [1:0]  state_q, state_d;
  logic [14:0] read_addr_q, read_addr_d;
  logic [7:0]  key_q, key_d;
  logic        v1_q, v1_d;
  logic [14:0] a1_q, a1_d;
  logic        we_q, we_d;
  logic [14:0] wa_q, wa_d;
  logic [7:0]  ed_q, ed_d;

  // Next-state logic: FSM, read address generation and the two-stage
  // valid/address pipeline (stage 1 = memory latency, stage 2 = output).
  always_comb begin
    state_d     = state_q;
    read_addr_d = read_addr_q;
    key_d       = key_q;
    v1_d        = 1'b0;
    a1_d        = a1_q;
    we_d        = v1_q;
    wa_d        = wa_q;
    ed_d        = ed_q;

    if (v1_q) begin
      wa_d = a1_q;
      ed_d = bus.plain_data ^ key_q;
`ifdef IMAGE_ENCRYPTER_ROLLING_KEY_EN
      key_d = {key_q[6:0], key_q[7]};
`else
      key_d = key_q;
`endif
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          read_addr_d = 15'd0;
          key_d       = KEY;
          state_d     = RUN;
        end
      end
      RUN: begin
        v1_d = 1'b1;
        a1_d = read_addr_q;
        if (read_addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          read_addr_d = read_addr_q + 15'd1;
        end
      end
      DRAIN: begin
        // Once stage 1 is empty the last write is on the bus this cycle.
        if (!v1_q) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset that aborts any pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      read_addr_q <= 15'd0;
      key_q       <= KEY;
      v1_q        <= 1'b0;
      a1_q        <= 15'd0;
      we_q        <= 1'b0;
      wa_q        <= 15'd0;
      ed_q        <= 8'd0;
    end else begin
      state_q     <= state_d;
      read_addr_q <= read_addr_d;
      key_q       <= key_d;
      v1_q        <= v1_d;
      a1_q        <= a1_d;
      we_q        <= we_d;
      wa_q        <= wa_d;
      ed_q        <= ed_d;
    end
  end

  assign bus.read_addr      = read_addr_q;
  assign bus.write_addr     = wa_q;
  assign bus.encrypted_data = ed_q;
  assign bus.write_en       = we_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.done           = (state_q == FIN);

endmodule

// File: tb/tb_image_encrypter.sv
// Testbench for image_encrypter: a 4-byte instance and a 1-byte instance,
// each fed by a small source memory, checked every cycle against a timing
// model derived from the pass start edge, plus hand-computed literals.
module tb_image_encrypter;

  localparam logic [7:0] KEY = 8'hB3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int cyc = 0;
  int passCount = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  image_encrypter_if bus4();
  image_encrypter_if bus1();

  image_encrypter #(.KEY(KEY), .NUM_BYTES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  image_encrypter #(.KEY(KEY), .NUM_BYTES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [7:0] mem4 [0:3];
  logic [7:0] mem1 = 8'h5A;

  int s4 = -1;
  int s1 = -1;
  logic [7:0] wlog4[$];
  int firstWr4 = -1;
  int doneEdge4 = -1;
  int doneCount4 = 0;
  int writeCount1 = 0;
  int doneEdges1[$];

  // Edge counter: inside a posedge process, cyc is the index of that edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read source memories with one cycle of latency.
  always @(posedge clk) begin
    bus4.plain_data <= mem4[bus4.read_addr[1:0]];
    bus1.plain_data <= mem1;
  end

  // A pass started at edge s keeps the block busy after edges s..s+n+2.
  function automatic bit busyAt(input int n, input int s, input int e);
    return (s >= 0) && (e >= s) && (e <= s + n + 2);
  endfunction

  function automatic logic [7:0] keyFor(input int k);
    logic [15:0] dbl;
`ifdef IMAGE_ENCRYPTER_ROLLING_KEY_EN
    dbl = {KEY, KEY} << (k % 8);
`else
    dbl = {KEY, KEY};
`endif
    return dbl[15:8];
  endfunction

  // Model: remember the edge at which each pass was accepted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s4 <= -1;
      s1 <= -1;
    end else begin
      if (bus4.start && !busyAt(4, s4, cyc - 1)) s4 <= cyc;
      if (bus1.start && !busyAt(1, s1, cyc - 1)) s1 <= cyc;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic checkDut(input string tag, input int n, input int s, input int e,
                          input logic [7:0] src, input logic we, input logic [14:0] wa,
                          input logic [7:0] ed, input logic [14:0] ra,
                          input logic busy, input logic done);
    int k;
    bit expWe;
    int expRa;
    k = e - s - 2;
    expWe = (s >= 0) && (k >= 0) && (k < n);
    checkOutput({tag, " write_en"}, {31'd0, we}, {31'd0, expWe});
    if (expWe) begin
      checkOutput({tag, " write_addr"}, {17'd0, wa}, k);
      checkOutput({tag, " encrypted_data"}, {24'd0, ed}, {24'd0, src ^ keyFor(k)});
    end
    checkOutput({tag, " done"}, {31'd0, done}, {31'd0, ((s >= 0) && (e == s + n + 2))});
    checkOutput({tag, " busy"}, {31'd0, busy}, {31'd0, busyAt(n, s, e)});
    expRa = (s < 0) ? 0 : ((e - s < n - 1) ? e - s : n - 1);
    checkOutput({tag, " read_addr"}, {17'd0, ra}, expRa);
  endtask

  // Compare process: check both instances one time unit after every edge.
  always @(posedge clk) begin
    int e;
    int k4;
    logic [7:0] src4;
    #1;
    e = cyc - 1;
    k4 = e - s4 - 2;
    src4 = (k4 >= 0 && k4 < 4) ? mem4[k4[1:0]] : 8'h00;
    checkDut("d4", 4, s4, e, src4, bus4.write_en, bus4.write_addr, bus4.encrypted_data,
             bus4.read_addr, bus4.busy, bus4.done);
    checkDut("d1", 1, s1, e, mem1, bus1.write_en, bus1.write_addr, bus1.encrypted_data,
             bus1.read_addr, bus1.busy, bus1.done);
    if (bus4.write_en === 1'b1) begin
      wlog4.push_back(bus4.encrypted_data);
      if (firstWr4 < 0) firstWr4 = e;
    end
    if (bus4.done === 1'b1) begin
      doneCount4++;
      doneEdge4 = e;
    end
    if (bus1.write_en === 1'b1) writeCount1++;
    if (bus1.done === 1'b1) doneEdges1.push_back(e);
  end

  task automatic clearLogs();
    wlog4.delete();
    firstWr4 = -1;
    doneEdge4 = -1;
    doneCount4 = 0;
    writeCount1 = 0;
    doneEdges1.delete();
  endtask

  // Pulse start of the 4-byte instance for one cycle; t is the sampling edge.
  task automatic applyStimulus(output int t);
    @(negedge clk);
    bus4.start = 1'b1;
    @(posedge clk);
    t = cyc;
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  initial begin
    int t;
    int t1;
    bit hit;
    logic [7:0] expData [0:3];
    mem4[0] = 8'h00;
    mem4[1] = 8'hFF;
    mem4[2] = 8'h3C;
    mem4[3] = 8'hB3;
`ifdef IMAGE_ENCRYPTER_ROLLING_KEY_EN
    expData[0] = 8'hB3; expData[1] = 8'h98; expData[2] = 8'hF2; expData[3] = 8'h2E;
`else
    expData[0] = 8'hB3; expData[1] = 8'h4C; expData[2] = 8'h8F; expData[3] = 8'h00;
`endif
    bus4.start = 1'b0;
    bus1.start = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset read_addr", {17'd0, bus4.read_addr}, 0);
    checkOutput("reset write_en", {31'd0, bus4.write_en}, 0);
    checkOutput("reset busy", {31'd0, bus4.busy}, 0);
    checkOutput("reset done", {31'd0, bus4.done}, 0);
    checkOutput("reset encrypted_data", {24'd0, bus4.encrypted_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single pass of 4 bytes: data, latency and done timing
    $display("[TB] single pass, 4 bytes");
    clearLogs();
    applyStimulus(t);
    repeat (12) @(negedge clk);
    checkOutput("pass1 write count", wlog4.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("pass1 byte %0d", i),
                  {24'd0, (i < wlog4.size()) ? wlog4[i] : 8'hxx}, {24'd0, expData[i]});
    end
    checkOutput("pass1 first write latency", firstWr4 - t, 2);
    checkOutput("pass1 done latency", doneEdge4 - t, 6);
    checkOutput("pass1 done count", doneCount4, 1);

    // Start pulsed while busy at address 2 must not restart the pass
    $display("[TB] start while busy");
    clearLogs();
    applyStimulus(t);
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus4.read_addr == 15'd2) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("busy-start reached addr 2", {31'd0, hit}, 1);
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("busy-start write count", wlog4.size(), 4);
    checkOutput("busy-start done count", doneCount4, 1);

    // Reset in the middle of a pass aborts it
    $display("[TB] reset mid-pass");
    clearLogs();
    applyStimulus(t);
    for (int i = 0; i < 10; i++) begin
      if (wlog4.size() == 2) break;
      @(negedge clk);
    end
    checkOutput("mid-reset writes before abort", wlog4.size(), 2);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset write_en", {31'd0, bus4.write_en}, 0);
    checkOutput("mid-reset busy", {31'd0, bus4.busy}, 0);
    checkOutput("mid-reset read_addr", {17'd0, bus4.read_addr}, 0);
    checkOutput("mid-reset write_addr", {17'd0, bus4.write_addr}, 0);
    checkOutput("mid-reset encrypted_data", {24'd0, bus4.encrypted_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("mid-reset no further writes", wlog4.size(), 2);
    checkOutput("mid-reset no done", doneCount4, 0);

    // NUM_BYTES=1 with start held high: back-to-back passes
    $display("[TB] back-to-back passes, 1 byte");
    clearLogs();
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    t1 = cyc;
    repeat (13) @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("b2b write count", writeCount1, 3);
    checkOutput("b2b done count", doneEdges1.size(), 3);
    if (doneEdges1.size() == 3) begin
      checkOutput("b2b first done latency", doneEdges1[0] - t1, 3);
      checkOutput("b2b pass spacing 1", doneEdges1[1] - doneEdges1[0], 5);
      checkOutput("b2b pass spacing 2", doneEdges1[2] - doneEdges1[1], 5);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
